cpu0_ifetch: RTL

Instruction-fetch front end for the CPU0 core. It sits between the byte-addressed instruction memory and the decode/execute stage. It issues word reads to memory, buffers returned 32-bit big-endian instruction words in a small prefetch FIFO, and hands them to decode with their fetch address. Jump/branch redirects from execute flush the buffer and restart fetching at the new PC.

---
 rtl/cpu0_pkg.sv | 21 ++
 rtl/cpu0_ifetch_fifo.sv | 66 ++++++
 rtl/cpu0_ifetch.sv | 114 +++++++++++
 3 files changed

// File: rtl/cpu0_pkg.sv
// Shared CPU0 definitions: word/instruction widths, default reset PC and the
// fetch-entry record handed from instruction fetch to decode.
package cpu0_pkg;

  localparam int WORD_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0]  pc;
    logic [INSTR_W-1:0] word;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/cpu0_ifetch_fifo.sv
// Synchronous prefetch FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally.
module cpu0_ifetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cpu0_ifetch.sv
// CPU0 instruction fetch: one-outstanding word requests into a prefetch FIFO,
// flushed by redirects. Optional same-cycle bypass: CPU0_IFETCH_BYPASS_EN.
module cpu0_ifetch
  import cpu0_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic                mem_req,
  output logic [WORD_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [INSTR_W-1:0]  mem_rdata,
  output logic                ir_valid,
  output logic [INSTR_W-1:0]  ir_data,
  output logic [WORD_W-1:0]   ir_pc,
  input  logic                ir_ready,
  input  logic                redirect,
  input  logic [WORD_W-1:0]   redirect_pc
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic              mem_req_q, mem_req_d;
  logic              drop_q, drop_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_W-1:0] issue_pc;
  logic              ack_v, bypass, pop, fifo_pop, push;
  logic [CW-1:0]     fifo_count, count_next;
  logic              fifo_full, fifo_empty, unused_full;
  fetch_entry_t      head, wr_entry;

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign unused_full = fifo_full;

  cpu0_ifetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (fifo_pop),
    .flush   (redirect),
    .din     (wr_entry),
    .dout    (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    // An ack with no request in flight is a protocol violation and is ignored.
    ack_v = mem_ack & mem_req_q;
`ifdef CPU0_IFETCH_BYPASS_EN
    bypass = fifo_empty & ~drop_q & ack_v;
`else
    bypass = 1'b0;
`endif
    ir_valid = ~fifo_empty | bypass;
    ir_data  = '0;
    ir_pc    = '0;
    if (bypass) begin
      ir_data = mem_rdata;
      ir_pc   = mem_addr_q;
    end else if (!fifo_empty) begin
      ir_data = head.word;
      ir_pc   = head.pc;
    end

    pop           = ir_valid & ir_ready & ~redirect;
    fifo_pop      = pop & ~fifo_empty;
    push          = ack_v & ~drop_q & ~redirect & ~(bypass & pop);
    wr_entry.pc   = mem_addr_q;
    wr_entry.word = mem_rdata;
    count_next    = redirect ? '0 : fifo_count + CW'(push) - CW'(fifo_pop);

    issue_pc   = redirect ? word_align(redirect_pc) : fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = issue_pc;
    drop_d     = drop_q;
    if (mem_req_q && !mem_ack) begin
      // Request stays on the bus; a redirect only marks its data for discard.
      if (redirect) drop_d = 1'b1;
    end else begin
      drop_d    = 1'b0;
      mem_req_d = (count_next < DEPTH_C);
      if (mem_req_d) begin
        mem_addr_d = issue_pc;
        fetch_pc_d = issue_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_q  <= 1'b0;
      drop_q     <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      mem_req_q  <= mem_req_d;
      drop_q     <= drop_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

endmodule
